// File: rtl/hough_pkg.sv
// Shared types and sizes for the Hough line detector.
package hough_pkg;

  localparam int COORD_W = 8;
  localparam int C_BINS  = 256;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    ACCUM,
    DRAIN,
    SCAN
  } state_t;

endpackage

// File: rtl/hough_line_detect_hist_ram.sv
// Intercept histogram: simple dual-port RAM, registered read, contents not reset.
module hough_hist_ram
  import hough_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               Clk,
  input  logic               we,
  input  logic [COORD_W-1:0] waddr,
  input  logic [COUNT_W-1:0] wdata,
  input  logic [COORD_W-1:0] raddr,
  output logic [COUNT_W-1:0] rdata
);

  logic [COUNT_W-1:0] mem [C_BINS];
  logic [COUNT_W-1:0] rdata_q;

  // A read and write to the same bin in one cycle returns the old contents.
  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hough_line_detect.sv
// Hough accumulator for one frame-latched slope: votes edge pixels into
// intercept bins, then scans for the best bin and reports it.
//
// state | meaning
// CLEAR | zero bins 0..255, one per cycle
// IDLE  | Ready; next FrameIn latches m and starts voting
// ACCUM | vote edge pixels; next FrameIn ends the frame
// DRAIN | retire the final read-modify-write
// SCAN  | read all bins, track maximum, then pulse Valid
module hough_line_detect
  import hough_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               nReset,
  input  logic               Clk,
  input  logic [7:0]         PixelIn,
  input  logic               FrameIn,
  input  logic               LineIn,
  input  logic [7:0]         m,
  input  logic [7:0]         Threshold,
  output logic               Ready,
  output logic [7:0]         MDetect,
  output logic [7:0]         CDetect,
  output logic [COUNT_W-1:0] Count,
  output logic               Valid
);

  localparam logic [COORD_W:0] LAST_BIN  = (COORD_W+1)'(C_BINS - 1);
  localparam logic [COORD_W:0] SCAN_DONE = (COORD_W+1)'(C_BINS);

  state_t               state_q, state_d;
  logic [COORD_W:0]     addr_q, addr_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [7:0]           m_lat_q, m_lat_d;
  logic                 v1_q, v1_d;
  logic [COORD_W-1:0]   c1_q, c1_d;
  logic                 fwd_q, fwd_d;
  logic [COUNT_W-1:0]   fwd_val_q, fwd_val_d;
  logic                 scan_v_q, scan_v_d;
  logic [COORD_W-1:0]   scan_idx_q, scan_idx_d;
  logic [COORD_W-1:0]   best_c_q, best_c_d;
  logic [COUNT_W-1:0]   best_n_q, best_n_d;
  logic [7:0]           mdet_q, mdet_d, cdet_q, cdet_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 valid_q, valid_d;

  logic [COORD_W-1:0]   mx, c0, ram_waddr, ram_raddr;
  logic [COUNT_W-1:0]   ram_rdata, ram_wdata, vote_cnt, vote_wdata;
  logic                 vote0, ram_we;

  hough_hist_ram #(.COUNT_W(COUNT_W)) u_ram (
    .Clk   (Clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    mx    = 8'(m_lat_q * x_q);
    c0    = y_q - mx;
    vote0 = (state_q == ACCUM) && !FrameIn && !LineIn && (PixelIn >= Threshold);

    // RAM data is stale when the previous vote hit the same bin; use its result.
    vote_cnt   = fwd_q ? fwd_val_q : ram_rdata;
    vote_wdata = (&vote_cnt) ? vote_cnt : vote_cnt + 1'b1;

    ram_we    = (state_q == CLEAR) || v1_q;
    ram_waddr = (state_q == CLEAR) ? addr_q[COORD_W-1:0] : c1_q;
    ram_wdata = (state_q == CLEAR) ? '0 : vote_wdata;
    ram_raddr = (state_q == SCAN) ? addr_q[COORD_W-1:0] : c0;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    m_lat_d    = m_lat_q;
    v1_d       = vote0;
    c1_d       = c0;
    fwd_d      = vote0 && v1_q && (c1_q == c0);
    fwd_val_d  = vote_wdata;
    scan_v_d   = 1'b0;
    scan_idx_d = addr_q[COORD_W-1:0];
    best_c_d   = best_c_q;
    best_n_d   = best_n_q;
    mdet_d     = mdet_q;
    cdet_d     = cdet_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;

    if (FrameIn) begin
      x_d = '0;
      y_d = '0;
    end else if (LineIn) begin
      x_d = '0;
      y_d = y_q + 1'b1;
    end else begin
      x_d = x_q + 1'b1;
      y_d = y_q;
    end

    // Strictly greater keeps the lowest intercept on ties.
    if (scan_v_q && (ram_rdata > best_n_q)) begin
      best_n_d = ram_rdata;
      best_c_d = scan_idx_q;
    end

    case (state_q)
      CLEAR: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_BIN) begin
          addr_d  = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (FrameIn) begin
          m_lat_d = m;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (FrameIn) state_d = DRAIN;
      end
      DRAIN: begin
        addr_d   = '0;
        best_c_d = '0;
        best_n_d = '0;
        state_d  = SCAN;
      end
      SCAN: begin
        if (addr_q == SCAN_DONE) begin
          addr_d  = '0;
          valid_d = 1'b1;
          mdet_d  = m_lat_q;
          cdet_d  = best_c_d;
          cnt_d   = best_n_d;
          state_d = CLEAR;
        end else begin
          scan_v_d = 1'b1;
          addr_d   = addr_q + 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= CLEAR;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      m_lat_q    <= '0;
      v1_q       <= 1'b0;
      c1_q       <= '0;
      fwd_q      <= 1'b0;
      fwd_val_q  <= '0;
      scan_v_q   <= 1'b0;
      scan_idx_q <= '0;
      best_c_q   <= '0;
      best_n_q   <= '0;
      mdet_q     <= '0;
      cdet_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      m_lat_q    <= m_lat_d;
      v1_q       <= v1_d;
      c1_q       <= c1_d;
      fwd_q      <= fwd_d;
      fwd_val_q  <= fwd_val_d;
      scan_v_q   <= scan_v_d;
      scan_idx_q <= scan_idx_d;
      best_c_q   <= best_c_d;
      best_n_q   <= best_n_d;
      mdet_q     <= mdet_d;
      cdet_q     <= cdet_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
    end
  end

  assign Ready   = (state_q == IDLE);
  assign MDetect = mdet_q;
  assign CDetect = cdet_q;
  assign Count   = cnt_q;
  assign Valid   = valid_q;

endmodule

// File: tb/tb_hough_line_detect.sv
// Bench for hough_line_detect: directed frame table, random frames against a
// histogram model, reset/ignored-FrameIn sequences. Two widths run in lockstep.
module tb_hough_line_detect;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] PixelIn = '0;
  logic       FrameIn = 1'b0;
  logic       LineIn = 1'b0;
  logic [7:0] m = '0;
  logic [7:0] Threshold = '0;

  logic        Ready, Valid, Ready4, Valid4;
  logic [7:0]  MDetect, CDetect, MDetect4, CDetect4;
  logic [15:0] Count;
  logic [3:0]  Count4;

  int n_tests = 0;
  int n_fail  = 0;

  byte unsigned pix [64][64];

  typedef struct {
    int kind; int w; int h; int mm; int thr;
    int c16; int n16; int c4; int n4;
  } vec_t;
  vec_t vecs [6];

  hough_line_detect #(.COUNT_W(16)) dut (
    .nReset(nReset), .Clk(Clk), .PixelIn(PixelIn), .FrameIn(FrameIn), .LineIn(LineIn),
    .m(m), .Threshold(Threshold), .Ready(Ready), .MDetect(MDetect), .CDetect(CDetect),
    .Count(Count), .Valid(Valid)
  );

  hough_line_detect #(.COUNT_W(4)) dut4 (
    .nReset(nReset), .Clk(Clk), .PixelIn(PixelIn), .FrameIn(FrameIn), .LineIn(LineIn),
    .m(m), .Threshold(Threshold), .Ready(Ready4), .MDetect(MDetect4), .CDetect(CDetect4),
    .Count(Count4), .Valid(Valid4)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic fill(input int kind, input int w, input int h);
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) pix[r][c] = 8'h00;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        case (kind)
          0: if (r == 5) pix[r][c] = 8'hFF;
          1: if (r == c + 3) pix[r][c] = 8'hFF;
          2: if (r == 10 && c == 20) pix[r][c] = 8'hFF;
          3: if (r == 2) pix[r][c] = 8'hFF;
          4: if (r == 3 || r == 7) pix[r][c] = 8'hFF;
          6: pix[r][c] = 8'($urandom_range(0, 255));
          default: ;
        endcase
      end
  endtask

  // Reference: count edges per intercept bin, clip to the bin width, take first maximum.
  task automatic model(input int w, input int h, input int mm, input int thr, input int cw,
                       output int bc, output int bn);
    int hist [256];
    int sat, v;
    for (int i = 0; i < 256; i++) hist[i] = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (int'(pix[r][c]) >= thr) hist[(r - mm * c) & 255]++;
    sat = (1 << cw) - 1;
    bc = 0;
    bn = 0;
    for (int i = 0; i < 256; i++) begin
      v = (hist[i] > sat) ? sat : hist[i];
      if (v > bn) begin
        bn = v;
        bc = i;
      end
    end
  endtask

  task automatic run_frame(input int w, input int h, input int mm, input int thr, input bit poke,
                           input int c16, input int n16, input int c4, input int n4);
    int waited = 0;
    bit early = 1'b0;
    FrameIn = 1'b0; LineIn = 1'b0; PixelIn = 8'hFF; Threshold = 8'h00;
    while (Ready !== 1'b1 && waited < 1000) begin
      @(negedge Clk);
      waited++;
    end
    check("ready_before_frame", Ready, 1);
    repeat (2) @(negedge Clk);
    FrameIn = 1'b1; m = 8'(mm);
    @(negedge Clk);
    FrameIn = 1'b0; Threshold = 8'(thr); m = 8'($urandom_range(0, 255));
    for (int r = 0; r < h; r++) begin
      if (r > 0) begin
        LineIn = 1'b1; PixelIn = 8'hFF;
        @(negedge Clk);
        LineIn = 1'b0;
      end
      for (int c = 0; c < w; c++) begin
        PixelIn = pix[r][c];
        @(negedge Clk);
      end
    end
    FrameIn = 1'b1; PixelIn = 8'hFF;
    @(negedge Clk);
    for (int i = 1; i <= 515; i++) begin
      if (i == 259) begin
        check("valid_at_k259", Valid, 1);
        check("valid4_at_k259", Valid4, 1);
        check("mdetect", MDetect, 32'(mm & 255));
        check("cdetect", CDetect, 32'(c16));
        check("count", Count, 32'(n16));
        check("cdetect_w4", CDetect4, 32'(c4));
        check("count_w4", Count4, 32'(n4));
      end else if (Valid !== 1'b0 || Valid4 !== 1'b0) begin
        early = 1'b1;
      end
      if (i == 514) check("ready_low_k514", Ready, 0);
      if (i == 515) begin
        check("ready_high_k515", Ready, 1);
        check("cdetect_hold", CDetect, 32'(c16));
        check("valid_only_k259", 32'(early), 0);
      end
      FrameIn = poke && (i == 1 || i == 100 || i == 300);
      PixelIn = 8'($urandom_range(0, 255));
      Threshold = 8'($urandom_range(0, 255));
      if (i < 515) @(negedge Clk);
    end
    FrameIn = 1'b0;
  endtask

  // Release reset at a negedge and watch the clear sweep; a FrameIn during CLEAR must be ignored.
  task automatic reset_release_check;
    int first_high = -1;
    bit dropped = 1'b0;
    bit vany = 1'b0;
    nReset = 1'b1;
    #1;
    for (int n = 1; n <= 300; n++) begin
      if (n > 1) @(negedge Clk);
      if (Valid !== 1'b0 || Valid4 !== 1'b0) vany = 1'b1;
      if (Ready === 1'b1 && first_high < 0) first_high = n;
      if (Ready !== 1'b1 && first_high >= 0) dropped = 1'b1;
      FrameIn = (n == 100);
    end
    FrameIn = 1'b0;
    check("ready_first_cycle", 32'(first_high), 257);
    check("ready_stays_high", 32'(dropped), 0);
    check("no_valid_after_reset", 32'(vany), 0);
    check("mdetect_reset", MDetect, 0);
    check("cdetect_reset", CDetect, 0);
    check("count_reset", Count, 0);
  endtask

  initial begin
    int bc16, bn16, bc4, bn4, w, h, mm, thr;

    vecs[0] = '{kind:0, w:16, h:16, mm:0,    thr:8'h80, c16:5,   n16:16, c4:5,   n4:15};
    vecs[1] = '{kind:1, w:32, h:32, mm:1,    thr:8'h80, c16:3,   n16:29, c4:3,   n4:15};
    vecs[2] = '{kind:2, w:32, h:32, mm:3,    thr:8'h80, c16:206, n16:1,  c4:206, n4:1};
    vecs[3] = '{kind:3, w:20, h:4,  mm:0,    thr:8'h80, c16:2,   n16:20, c4:2,   n4:15};
    vecs[4] = '{kind:4, w:8,  h:10, mm:0,    thr:8'h80, c16:3,   n16:8,  c4:3,   n4:8};
    vecs[5] = '{kind:5, w:8,  h:8,  mm:8'h2A, thr:8'h80, c16:0,  n16:0,  c4:0,   n4:0};

    repeat (2) @(negedge Clk);
    check("ready_in_reset", Ready, 0);
    check("valid_in_reset", Valid, 0);
    reset_release_check();

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].kind, vecs[v].w, vecs[v].h);
      run_frame(vecs[v].w, vecs[v].h, vecs[v].mm, vecs[v].thr, (v == 1 || v == 3),
                vecs[v].c16, vecs[v].n16, vecs[v].c4, vecs[v].n4);
    end

    for (int f = 0; f < 6; f++) begin
      w   = $urandom_range(4, 32);
      h   = $urandom_range(4, 32);
      mm  = (f == 0) ? 0 : $urandom_range(0, 255);
      thr = $urandom_range(96, 255);
      fill(6, w, h);
      model(w, h, mm, thr, 16, bc16, bn16);
      model(w, h, mm, thr, 4, bc4, bn4);
      run_frame(w, h, mm, thr, f[0], bc16, bn16, bc4, bn4);
    end

    // Non-zero result in place, then abort an accumulation with reset.
    fill(vecs[2].kind, vecs[2].w, vecs[2].h);
    run_frame(vecs[2].w, vecs[2].h, vecs[2].mm, vecs[2].thr, 1'b0,
              vecs[2].c16, vecs[2].n16, vecs[2].c4, vecs[2].n4);
    @(negedge Clk);
    check("ready_before_abort", Ready, 1);
    FrameIn = 1'b1; m = 8'd7;
    @(negedge Clk);
    FrameIn = 1'b0; Threshold = 8'h00; PixelIn = 8'hFF;
    repeat (10) @(negedge Clk);
    nReset = 1'b0;
    #1;
    check("abort_mdetect", MDetect, 0);
    check("abort_cdetect", CDetect, 0);
    check("abort_count", Count, 0);
    check("abort_ready", Ready, 0);
    check("abort_valid", Valid, 0);
    repeat (2) @(negedge Clk);
    reset_release_check();

    fill(vecs[0].kind, vecs[0].w, vecs[0].h);
    run_frame(vecs[0].w, vecs[0].h, vecs[0].mm, vecs[0].thr, 1'b0,
              vecs[0].c16, vecs[0].n16, vecs[0].c4, vecs[0].n4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
